// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder, one bit per clock
// Optional signed-overflow flag (ovf port) enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             s_bit;
    logic             c_nxt;

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nxt    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sum fills from the MSB end so after WIDTH shifts bit 0 lands in sum[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                    end
                end
                RUN: begin
                    sum   <= {s_bit, sum[WIDTH-1:1]};
                    carry <= c_nxt;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        cout <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf  <= carry ^ c_nxt;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand shifters carry no reset; their contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && start) begin
            a_sh <= a;
            b_sh <= b;
        end else if (state_q == RUN) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int tests_run;
    int tests_failed;
    int overlap_cnt;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && busy && done) overlap_cnt++;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return (W+1)'(t % (1 << (W + 1)));
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx, sy, r;
        sx = (int'(x) >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
        sy = (int'(y) >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
        r  = sx + sy + int'(c);
        return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         output logic [W-1:0] rs, output logic rc, output logic ro,
                         output int lat, output int dlen);
        @(negedge clk);
        a = ta; b = tb; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= W + 10; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        rs = sum; rc = cout;
`ifdef SERIAL_ADDER_OVF_EN
        ro = ovf;
`else
        ro = 1'b0;
`endif
        @(posedge clk); #1;
        dlen = done ? 2 : 1;
    endtask

    task automatic test_reset();
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, sum, cout} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
        end
`ifdef SERIAL_ADDER_OVF_EN
        tests_run++;
        if (ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ovf got %b want 0", ovf);
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [W-1:0] va[3], vb[3], rs, held;
        logic         vc[3], rc, ro;
        logic [W:0]   exp;
        int           lat, dlen;
        va = '{8'h00, 8'hFF, 8'hFF};
        vb = '{8'h00, 8'h01, 8'hFF};
        vc = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], rs, rc, ro, lat, dlen);
            exp = ref_add(va[i], vb[i], vc[i]);
            tests_run++;
            if ({rc, rs} !== exp) begin
                tests_failed++;
                $display("FAIL vec%0d_result got %h want %h", i, {rc, rs}, exp);
            end
            tests_run++;
            if (lat !== W) begin
                tests_failed++;
                $display("FAIL vec%0d_latency got %0d want %0d", i, lat, W);
            end
            tests_run++;
            if (dlen !== 1) begin
                tests_failed++;
                $display("FAIL vec%0d_done_len got %0d want 1", i, dlen);
            end
        end
        held = sum;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        tests_run++;
        if (sum !== 8'hFF || cout !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold got sum=%h cout=%b busy=%b want sum=%h cout=1 busy=0", sum, cout, busy, held);
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] va[3], vb[3], rs;
        logic         rc, ro;
        logic [W:0]   exp;
        int           lat, dlen;
        va = '{8'h7F, 8'h80, 8'h05};
        vb = '{8'h01, 8'h80, 8'h03};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 1'b0, rs, rc, ro, lat, dlen);
            exp = ref_add(va[i], vb[i], 1'b0);
            tests_run++;
            if ({ro, rc, rs} !== {ref_ovf(va[i], vb[i], 1'b0), exp}) begin
                tests_failed++;
                $display("FAIL ovf%0d got ovf=%b res=%h want ovf=%b res=%h", i, ro, {rc, rs},
                         ref_ovf(va[i], vb[i], 1'b0), exp);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] opa[64], opb[64];
        logic         opc[64];
        logic         exp_done;
        logic [W:0]   exp;
        int           last_done;
        int           e_acc;
        @(negedge clk);
        opa[0] = W'($urandom); opb[0] = W'($urandom); opc[0] = 1'($urandom);
        a = opa[0]; b = opb[0]; cin = opc[0]; start = 1'b1;
        last_done = -1;
        for (int e = 0; e <= 4 * (W + 2); e++) begin
            @(posedge clk); #1;
            exp_done = (e >= W) && (((e - W) % (W + 2)) == 0);
            tests_run++;
            if (done !== exp_done) begin
                tests_failed++;
                $display("FAIL b2b_done_edge%0d got %b want %b", e, done, exp_done);
            end
            if (done && exp_done) begin
                e_acc = e - W;
                exp = ref_add(opa[e_acc], opb[e_acc], opc[e_acc]);
                tests_run++;
                if ({cout, sum} !== exp) begin
                    tests_failed++;
                    $display("FAIL b2b_result_edge%0d got %h want %h", e, {cout, sum}, exp);
                end
                if (last_done >= 0) begin
                    tests_run++;
                    if (e - last_done !== W + 2) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing got %0d want %0d", e - last_done, W + 2);
                    end
                end
                last_done = e;
            end
            opa[e+1] = W'($urandom); opb[e+1] = W'($urandom); opc[e+1] = 1'($urandom);
            a = opa[e+1]; b = opb[e+1]; cin = opc[e+1];
        end
        start = 1'b0;
        repeat (2 * W + 4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        logic [W:0] exp;
        @(negedge clk);
        a = 8'hA5; b = 8'h3C; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset got busy=%b done=%b sum=%h cout=%b want 0 0 00 0", busy, done, sum, cout);
        end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || seen_done !== 0) begin
            tests_failed++;
            $display("FAIL midrun_restart got busy=%b stray_done=%0d want busy=1 stray_done=0", busy, seen_done);
        end
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        exp = ref_add(8'h12, 8'h34, 1'b0);
        tests_run++;
        if (done !== 1'b1 || {cout, sum} !== exp) begin
            tests_failed++;
            $display("FAIL midrun_after got done=%b res=%h want done=1 res=%h", done, {cout, sum}, exp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb, rs;
        logic         tc, rc, ro;
        logic [W:0]   exp;
        int           lat, dlen;
        overlap_cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            ta = W'($urandom); tb = W'($urandom); tc = 1'($urandom);
            do_op(ta, tb, tc, rs, rc, ro, lat, dlen);
            exp = ref_add(ta, tb, tc);
            tests_run++;
            if ({rc, rs} !== exp || lat !== W) begin
                tests_failed++;
                $display("FAIL rand%0d a=%h b=%h cin=%b got res=%h lat=%0d want res=%h lat=%0d",
                         n, ta, tb, tc, {rc, rs}, lat, exp, W);
            end
`ifdef SERIAL_ADDER_OVF_EN
            tests_run++;
            if (ro !== ref_ovf(ta, tb, tc)) begin
                tests_failed++;
                $display("FAIL rand%0d_ovf got %b want %b", n, ro, ref_ovf(ta, tb, tc));
            end
`endif
        end
        tests_run++;
        if (overlap_cnt !== 0) begin
            tests_failed++;
            $display("FAIL busy_done_overlap got %0d cycles want 0", overlap_cnt);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        overlap_cnt = 0;
        test_reset();
        test_vectors();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
